// File: rtl/g_alu32_resfifo.sv
// g_alu32_resfifo: in-order FIFO for ALU result/carry/opcode with valid/ready ports.
// Define ALU32_RESFIFO_FLAGS_EN to store zero/neg flags with each entry.
module g_alu32_resfifo #(
    parameter int AW = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          In_Valid,
    output logic          In_Ready,
    input  logic [31:0]   FinalOut,
    input  logic          CO,
    input  logic [2:0]    A,
    output logic          Out_Valid,
    input  logic          Out_Ready,
    output logic [31:0]   Out_Data,
    output logic          Out_CO,
    output logic [2:0]    Out_A,
    output logic          Out_Zero,
    output logic          Out_Neg,
    output logic [AW:0]   Count,
    output logic          Ovf
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
`ifdef ALU32_RESFIFO_FLAGS_EN
    localparam int EW = 38;
`else
    localparam int EW = 36;
`endif
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] entry, head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    assign In_Ready  = (Count != FULL) && !RST;
    assign Out_Valid = Count != '0;
    assign push      = In_Valid && In_Ready;
    assign pop       = Out_Valid && Out_Ready;
`ifdef ALU32_RESFIFO_FLAGS_EN
    assign entry     = {FinalOut[31], FinalOut == 32'h0, A, CO, FinalOut};
    assign Out_Neg   = head[37];
    assign Out_Zero  = head[36];
`else
    assign entry     = {A, CO, FinalOut};
    assign Out_Neg   = 1'b0;
    assign Out_Zero  = 1'b0;
`endif
    assign head      = Out_Valid ? mem[rd_ptr] : '0;
    assign Out_Data  = head[31:0];
    assign Out_CO    = head[32];
    assign Out_A     = head[35:33];
    // storage is intentionally not reset; Out_Valid masks stale contents
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= entry;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            Count  <= '0;
            Ovf    <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            Count  <= Count + (AW+1)'(push) - (AW+1)'(pop);
            if (In_Valid && Count == FULL) Ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_g_alu32_resfifo.sv
// tb_g_alu32_resfifo: scoreboard bench for g_alu32_resfifo (AW=2).
module tb_g_alu32_resfifo;
    logic        CLK = 1'b0;
    logic        RST, In_Valid, In_Ready, CO, Out_Valid, Out_Ready;
    logic        Out_CO, Out_Zero, Out_Neg, Ovf;
    logic [31:0] FinalOut, Out_Data;
    logic [2:0]  A, Out_A;
    logic [2:0]  Count;
    int          n_pass = 0, n_chk = 0;
    logic [37:0] q[$];
`ifdef ALU32_RESFIFO_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    g_alu32_resfifo #(.AW(2)) dut (
        .CLK(CLK), .RST(RST), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .FinalOut(FinalOut), .CO(CO), .A(A), .Out_Valid(Out_Valid),
        .Out_Ready(Out_Ready), .Out_Data(Out_Data), .Out_CO(Out_CO), .Out_A(Out_A),
        .Out_Zero(Out_Zero), .Out_Neg(Out_Neg), .Count(Count), .Ovf(Ovf)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [37:0] mk(input logic [31:0] d, input logic c, input logic [2:0] a);
        return {FLAGS & d[31], FLAGS & (d == 32'h0), a, c, d};
    endfunction

    // sample at negedge against the model, then advance past the next rising edge
    task automatic cyc;
        @(negedge CLK);
        if (RST) q.delete();
        else begin
            chk("count", Count, q.size());
            chk("in_ready", In_Ready, q.size() < 4);
            chk("out_valid", Out_Valid, q.size() != 0);
            if (!Out_Valid) chk("idle_zero", {Out_Neg, Out_Zero, Out_A, Out_CO, Out_Data}, 0);
            else if (q.size() != 0) begin
                chk("head", {Out_Neg, Out_Zero, Out_A, Out_CO, Out_Data}, q[0]);
                if (Out_Ready) void'(q.pop_front());
            end
            if (In_Valid && In_Ready) q.push_back(mk(FinalOut, CO, A));
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [2:0] a, input logic c);
        In_Valid = v;
        FinalOut = d;
        A = a;
        CO = c;
    endtask

    initial begin
        RST = 1'b1;
        Out_Ready = 1'b0;
        drive(1'b1, 32'h77, 3'd0, 1'b0);
        @(posedge CLK);
        #1;
        chk("rst_count", Count, 0);
        chk("rst_valid", Out_Valid, 0);
        chk("rst_in_ready", In_Ready, 0);
        chk("rst_data", Out_Data, 0);
        cyc();
        RST = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        #1;
        chk("post_rst_in_ready", In_Ready, 1);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (i == 3) ? 32'hFFFF_FFFF : 32'(i + 1), 3'd4, i == 3);
            cyc();
        end
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        chk("full_count", Count, 4);
        chk("full_in_ready", In_Ready, 0);

        drive(1'b1, 32'hDEAD, 3'd1, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        chk("ovf_set", Ovf, 1);
        chk("ovf_count", Count, 4);
        cyc();
        chk("ovf_sticky", Ovf, 1);

        Out_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", Out_Data, (i == 3) ? 32'hFFFF_FFFF : 32'(i + 1));
            chk("drain_co", Out_CO, i == 3);
            cyc();
        end
        chk("drained_valid", Out_Valid, 0);
        chk("ovf_after_drain", Ovf, 1);

        Out_Ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 3'(i), 1'b0);
            cyc();
        end
        Out_Ready = 1'b1;
        for (int i = 2; i < 12; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 3'(i), i[0]);
            cyc();
            chk("pp_count", Count, 2);
        end
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        cyc();
        cyc();
        chk("pp_empty", Out_Valid, 0);

        drive(1'b1, 32'h0, 3'd2, 1'b0);
        cyc();
        chk("zero_data", Out_Data, 32'h0);
        chk("zero_flag", Out_Zero, FLAGS);
        chk("zero_neg", Out_Neg, 0);
        drive(1'b1, 32'h8000_0000, 3'd3, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        chk("neg_data", Out_Data, 32'h8000_0000);
        chk("neg_flag", Out_Neg, FLAGS);
        chk("neg_zero", Out_Zero, 0);
        cyc();
        chk("flags_empty", Out_Valid, 0);

        Out_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 3'd5, 1'b1);
            cyc();
        end
        chk("mid_count", Count, 3);
        RST = 1'b1;
        drive(1'b1, 32'h99, 3'd6, 1'b0);
        cyc();
        RST = 1'b0;
        chk("mid_rst_count", Count, 0);
        chk("mid_rst_valid", Out_Valid, 0);
        chk("mid_rst_ovf", Ovf, 0);
        drive(1'b1, 32'h55, 3'd7, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        chk("first_after_rst", Out_Data, 32'h55);
        chk("first_after_rst_a", Out_A, 3'd7);
        Out_Ready = 1'b1;
        cyc();

        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            if (i[2:0] == 3'd0) drive(1'b1, 32'h0, 3'($urandom_range(0, 7)), 1'b0);
            Out_Ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        drive(1'b0, 32'h0, 3'd0, 1'b0);
        Out_Ready = 1'b1;
        repeat (5) cyc();
        chk("final_empty", Out_Valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
